regfile_nr2w: RTL and testbench
===============================

REGFILE_NR2W -- requirements
Module: regfile_nr2w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 32: number of entries, power of two, at least 2.
REQ-003 The block SHALL have parameter NRD, default 4: number of read ports, 1..8.
REQ-004 The block SHALL have parameter ZERO_REG, default 0: when 1, entry 0 always reads zero and ignores writes.
REQ-005 The block SHALL have parameter AW, default $clog2(DEPTH): address width, derived only and never overridden.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, all state updated on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port i_rd_en, input, NRD bits: per-port read enable.
REQ-009 The block SHALL have port i_rd_addr, input, NRD*AW bits: port k address in bits [k*AW +: AW].
REQ-010 The block SHALL have port o_rd_data, output, NRD*WIDTH bits: port k data in bits [k*WIDTH +: WIDTH], registered.
REQ-011 The block SHALL have ports i_wr1_en (1 bit), i_wr1_addr (AW bits) and i_wr1_data (WIDTH bits), all inputs: write port 1.
REQ-012 The block SHALL have ports i_wr2_en (1 bit), i_wr2_addr (AW bits) and i_wr2_data (WIDTH bits), all inputs: write port 2.

Function
REQ-013 Writes SHALL commit on the rising clk edge when the port's enable is 1; a port with enable 0 SHALL change no entry.
REQ-014 When both write ports are enabled to the same address, port 1 data SHALL be stored and port 2 discarded.
REQ-015 When both write ports are enabled to different addresses, both SHALL commit in the same cycle.
REQ-016 Reads SHALL be synchronous with 1-cycle latency: if i_rd_en[k]=1 at edge N, o_rd_data slice k SHALL show the entry at i_rd_addr slice k after edge N.
REQ-017 When i_rd_en[k]=0, o_rd_data slice k SHALL hold its previous value.
REQ-018 Read ports SHALL be independent: any number of ports may read the same or different addresses in one cycle with no stall.
REQ-019 Read-during-write to the same address with bypass compiled out (see REQ-027) SHALL return the old entry content.
REQ-020 With ZERO_REG=1, writes to address 0 SHALL be dropped, and reads of address 0 SHALL return 0, including when bypass is active.
REQ-021 Addresses SHALL be AW bits wide with no out-of-range case; no wrap or saturation logic is required.

Reset
REQ-022 On rst_n=0, all DEPTH entries SHALL clear to 0 asynchronously, without waiting for a clk edge.
REQ-023 On rst_n=0, all o_rd_data bits SHALL clear to 0 asynchronously.
REQ-024 While rst_n=0, write and read enables SHALL be ignored.
REQ-025 Reset deassertion SHALL be synchronised externally; the first edge with rst_n=1 SHALL act normally.
REQ-026 Assertion of rst_n mid-write SHALL leave that entry at 0.

Configuration
REQ-027 Macro REGFILE_NR2W_BYPASS_EN SHALL select write-to-read forwarding.
REQ-028 When REGFILE_NR2W_BYPASS_EN is defined, a read at edge N to an address being written at edge N SHALL return the new data.
REQ-029 When REGFILE_NR2W_BYPASS_EN is defined and both write ports target the read address, the forwarded data SHALL be port 1's (consistent with REQ-014).
REQ-030 When REGFILE_NR2W_BYPASS_EN is undefined, reads SHALL return the pre-edge content per REQ-019, and no forwarding muxes SHALL exist.

Verification
REQ-031 The bench SHALL cover: reset, then read all NRD ports at addresses 0..3 -> all data 0; wr1 writes addr 5 = 0xDEADBEEF, next cycle read port 0 addr 5 -> 0xDEADBEEF one cycle later.
REQ-032 The bench SHALL cover: wr1 addr 7 = 0x11 and wr2 addr 7 = 0x22 in the same cycle, then read addr 7 -> 0x11; wr1 addr 8 = 0x33 and wr2 addr 9 = 0x44 in the same cycle -> both read back.
REQ-033 The bench SHALL cover: addr 3 = 0xA, then write addr 3 = 0xB while reading addr 3 on the same edge -> 0xB with the bypass macro, 0xA without it.
REQ-034 The bench SHALL cover: ZERO_REG=1, write addr 0 = 0xFFFFFFFF, read addr 0 on that edge and later -> 0 in both builds.
REQ-035 The bench SHALL cover: port 2 reads addr 5 (0xDEADBEEF) with i_rd_en[2] then deasserted, and the address changed to 6 -> output stays 0xDEADBEEF.
REQ-036 The bench SHALL cover: after filling addrs 0..31 with value = address, pulse rst_n low between edges -> outputs 0 immediately, and all later reads return 0.

Source files
------------

// File: rtl/regfile_nr2w.sv
// regfile_nr2w: multi-read, dual-write register file with synchronous reads.
//
// Parameters
//   WIDTH    : data bits per entry
//   DEPTH    : number of entries (power of two, >= 2)
//   NRD      : number of read ports (1..8)
//   ZERO_REG : 1 -> entry 0 always reads zero and ignores writes
//   AW       : address width, derived from DEPTH; do not override
//
// Ports
//   clk, rst_n             : clock (rising edge), async active-low reset
//   i_rd_en   [NRD]        : per-port read enable
//   i_rd_addr [NRD*AW]     : port k address in [k*AW +: AW]
//   o_rd_data [NRD*WIDTH]  : port k data in [k*WIDTH +: WIDTH], registered,
//                            holds when the port is not enabled
//   i_wr1_*  / i_wr2_*     : two write ports; port 1 wins on an address clash
//
// Configuration
//   REGFILE_NR2W_BYPASS_EN : when defined, a read on the same edge as a write
//                            to that address returns the new data (port 1
//                            first). When undefined, reads return the
//                            pre-edge content and no forwarding logic exists.
module regfile_nr2w #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NRD      = 4,
   parameter int unsigned ZERO_REG = 0,
   parameter int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NRD-1:0]         i_rd_en,
   input  logic [NRD*AW-1:0]      i_rd_addr,
   output logic [NRD*WIDTH-1:0]   o_rd_data,
   input  logic                   i_wr1_en,
   input  logic [AW-1:0]          i_wr1_addr,
   input  logic [WIDTH-1:0]       i_wr1_data,
   input  logic                   i_wr2_en,
   input  logic [AW-1:0]          i_wr2_addr,
   input  logic [WIDTH-1:0]       i_wr2_data
);

   logic [WIDTH-1:0] mem_q     [DEPTH];
   logic [WIDTH-1:0] mem_d     [DEPTH];
   logic [WIDTH-1:0] rd_data_q [NRD];
   logic [WIDTH-1:0] rd_data_d [NRD];

   // Gated write enables: address 0 is read-only when ZERO_REG is set.
   logic wr1_ok_c;
   logic wr2_ok_c;

   always_comb begin : write_gate
      wr1_ok_c = i_wr1_en;
      wr2_ok_c = i_wr2_en;
      if (ZERO_REG != 0) begin
         if (i_wr1_addr == '0) wr1_ok_c = 1'b0;
         if (i_wr2_addr == '0) wr2_ok_c = 1'b0;
      end
   end

   // Next array contents; port 1 is applied last so it wins a same-address clash.
   always_comb begin : write_next
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr2_ok_c) mem_d[i_wr2_addr] = i_wr2_data;
      if (wr1_ok_c) mem_d[i_wr1_addr] = i_wr1_data;
   end

   // Per-port read data capture; disabled ports keep their last value.
   always_comb begin : read_next
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] val;
      addr = '0;
      val  = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         rd_data_d[k] = rd_data_q[k];
         addr         = i_rd_addr[k*AW +: AW];
         val          = mem_q[addr];
`ifdef REGFILE_NR2W_BYPASS_EN
         // Forward in-flight write data; port 1 checked last to take priority.
         if (wr2_ok_c && (i_wr2_addr == addr)) val = i_wr2_data;
         if (wr1_ok_c && (i_wr1_addr == addr)) val = i_wr1_data;
`endif
         if ((ZERO_REG != 0) && (addr == '0)) val = '0;
         if (i_rd_en[k]) rd_data_d[k] = val;
      end
   end

   // State registers with asynchronous clear of both array and read outputs.
   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         for (int unsigned k = 0; k < NRD; k++) begin
            rd_data_q[k] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         for (int unsigned k = 0; k < NRD; k++) begin
            rd_data_q[k] <= rd_data_d[k];
         end
      end
   end

   // Flatten the read registers onto the output bus.
   for (genvar g = 0; g < int'(NRD); g++) begin : g_rd_out
      assign o_rd_data[g*WIDTH +: WIDTH] = rd_data_q[g];
   end

endmodule

// File: tb/tb_regfile_nr2w.sv
// tb_regfile_nr2w: scoreboard bench for regfile_nr2w (ZERO_REG=1, 4 read ports).
// Stimulus is applied on the falling edge; the expected read bus for the next
// rising edge is pushed into a queue and a monitor compares it after that edge.
module tb_regfile_nr2w;

   localparam int unsigned W  = 32;
   localparam int unsigned D  = 32;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 5;
   localparam bit          ZR = 1'b1;
`ifdef REGFILE_NR2W_BYPASS_EN
   localparam bit          BYP = 1'b1;
`else
   localparam bit          BYP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    rd_en;
   logic [N*AW-1:0] rd_addr;
   logic [N*W-1:0]  rd_data;
   logic            wr1_en, wr2_en;
   logic [AW-1:0]   wr1_addr, wr2_addr;
   logic [W-1:0]    wr1_data, wr2_data;

   regfile_nr2w #(
      .WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_REG(1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data),
      .i_wr1_en  (wr1_en),
      .i_wr1_addr(wr1_addr),
      .i_wr1_data(wr1_data),
      .i_wr2_en  (wr2_en),
      .i_wr2_addr(wr2_addr),
      .i_wr2_data(wr2_data)
   );

   always #5 clk = ~clk;

   // Reference model: array contents and last value shown on each read port.
   logic [W-1:0]   m_mem [D];
   logic [W-1:0]   m_out [N];
   logic [N*W-1:0] exp_q [$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < int'(D); i++) m_mem[i] = '0;
      for (int k = 0; k < int'(N); k++) m_out[k] = '0;
   endtask

   // One cycle of stimulus; updates the model and queues the expected bus.
   task automatic op(input logic [N-1:0] re, input int a0, input int a1, input int a2, input int a3,
                     input bit e1, input int x1, input logic [W-1:0] d1,
                     input bit e2, input int x2, input logic [W-1:0] d2);
      int           av [N];
      logic [W-1:0] m_next [D];
      logic [N*W-1:0] e;
      @(negedge clk);
      av = '{a0, a1, a2, a3};
      rd_en = re;
      for (int k = 0; k < int'(N); k++) rd_addr[k*AW +: AW] = AW'(av[k]);
      wr1_en = e1; wr1_addr = AW'(x1); wr1_data = d1;
      wr2_en = e2; wr2_addr = AW'(x2); wr2_data = d2;
      if (rst_n) begin
         // Contents after this edge, from the write rules.
         m_next = m_mem;
         if (e2 && !(e1 && x1 == x2) && !(ZR && x2 == 0)) m_next[x2] = d2;
         if (e1 && !(ZR && x1 == 0)) m_next[x1] = d1;
         for (int k = 0; k < int'(N); k++) begin
            if (re[k]) begin
               m_out[k] = BYP ? m_next[av[k]] : m_mem[av[k]];
               if (ZR && av[k] == 0) m_out[k] = '0;
            end
            e[k*W +: W] = m_out[k];
         end
         exp_q.push_back(e);
         m_mem = m_next;
      end
   endtask

   task automatic idle();
      op('0, 0, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0, '0);
   endtask

   // Monitor: after each rising edge, compare all ports against the queued entry.
   initial begin : monitor
      logic [N*W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < int'(N); k++)
               check($sformatf("rd_port%0d", k), rd_data[k*W +: W], e[k*W +: W]);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected done");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int a [N];
      rst_n = 1'b1;
      rd_en = '0; rd_addr = '0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
      wr2_en = 1'b0; wr2_addr = '0; wr2_data = '0;
      model_clear();
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < int'(N); k++) check("reset_async", rd_data[k*W +: W], '0);

      // Enables active while reset is held must be ignored.
      op('1, 10, 10, 11, 11, 1'b1, 10, 32'h55, 1'b1, 11, 32'h66);
      op('1, 10, 10, 11, 11, 1'b1, 10, 32'h55, 1'b1, 11, 32'h66);
      idle();
      #2 rst_n = 1'b1;
      for (int k = 0; k < int'(N); k++) check("reset_hold", rd_data[k*W +: W], '0);

      op(4'hF, 0, 1, 2, 3, 1'b0, 0, '0, 1'b0, 0, '0);
      op(4'hF, 10, 11, 10, 11, 1'b0, 0, '0, 1'b0, 0, '0);

      // Basic write then read.
      op(4'h0, 0, 0, 0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, '0);
      op(4'h1, 5, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0, '0);

      // Same-address clash, then two different addresses.
      op(4'h0, 0, 0, 0, 0, 1'b1, 7, 32'h11, 1'b1, 7, 32'h22);
      op(4'h1, 7, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0, '0);
      op(4'h0, 0, 0, 0, 0, 1'b1, 8, 32'h33, 1'b1, 9, 32'h44);
      op(4'h3, 8, 9, 0, 0, 1'b0, 0, '0, 1'b0, 0, '0);

      // Read during write to the same address.
      op(4'h0, 0, 0, 0, 0, 1'b1, 3, 32'hA, 1'b0, 0, '0);
      op(4'h1, 3, 0, 0, 0, 1'b1, 3, 32'hB, 1'b0, 0, '0);
      op(4'h1, 3, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0, '0);
      op(4'h2, 0, 12, 0, 0, 1'b1, 12, 32'hAAAA, 1'b1, 12, 32'hBBBB);
      op(4'h4, 0, 0, 13, 0, 1'b0, 0, '0, 1'b1, 13, 32'hCCCC);

      // Zero register: writes dropped, reads zero on that edge and later.
      op(4'h3, 0, 0, 0, 0, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 32'hFFFFFFFF);
      op(4'h3, 0, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0, '0);

      // Disabled port holds its value while the address changes.
      op(4'h4, 0, 0, 5, 0, 1'b1, 6, 32'h1234, 1'b0, 0, '0);
      op(4'h0, 0, 0, 6, 0, 1'b0, 0, '0, 1'b0, 0, '0);
      op(4'h3, 6, 6, 6, 0, 1'b0, 0, '0, 1'b0, 0, '0);

      // Randomised traffic, biased toward a few addresses to provoke clashes.
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < int'(N); k++)
            a[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, D-1));
         op(N'($urandom), a[0], a[1], a[2], a[3],
            1'($urandom), ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, D-1)), $urandom,
            1'($urandom), ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, D-1)), $urandom);
      end

      // Fill value = address, read back a few, then pulse reset between edges.
      for (int i = 0; i < int'(D) / 2; i++)
         op(4'h0, 0, 0, 0, 0, 1'b1, 2*i, W'(2*i), 1'b1, 2*i+1, W'(2*i+1));
      op(4'hF, 31, 30, 29, 28, 1'b0, 0, '0, 1'b0, 0, '0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int k = 0; k < int'(N); k++) check("reset_pulse", rd_data[k*W +: W], '0);
      model_clear();
      #1 rst_n = 1'b1;
      for (int i = 0; i < int'(D) / int'(N); i++)
         op(4'hF, 4*i, 4*i+1, 4*i+2, 4*i+3, 1'b0, 0, '0, 1'b0, 0, '0);
      idle();
      idle();

      // Drain the scoreboard with a bounded wait.
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
